// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and defaults for the decoder scan sequencer.
package decoder_scan_sequencer_pkg;

  localparam int unsigned AddrWDefault  = 6;
  localparam int unsigned DwellWDefault = 4;
  localparam int unsigned Depth         = 2 ** AddrWDefault;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/decoder_scan_sequencer_dwell_timer.sv
// Loadable down-counter that flags when the current select has dwelt long enough.
module decoder_scan_sequencer_dwell_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load with cycles-1 so expire is seen in the final dwell cycle; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Drives a one-hot decoder's enable/select through a run of consecutive
// addresses, with a per-select dwell and a one-cycle enable-low gap between selects.
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrWDefault,
  parameter int unsigned DWELL_W = DwellWDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W:0]    count,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic               sel_en,
  output logic [ADDR_W-1:0]  sel_addr,
  output logic               busy,
  output logic               done
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    remain_q, remain_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               sel_en_q, sel_en_d;
  logic [ADDR_W-1:0]  sel_addr_q, sel_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_load_val;
  logic               tmr_expire;
  logic [DWELL_W-1:0] dwell_eff;

  // A dwell of zero behaves as one cycle.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  decoder_scan_sequencer_dwell_timer #(
    .Width (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .expire_o   (tmr_expire)
  );

  // Next-state, scan bookkeeping and timer reload on every entry to SELECT.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    dwell_d      = dwell_q;
    tmr_load     = 1'b0;
    tmr_load_val = dwell_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          addr_d       = start_addr;
          remain_d     = count;
          dwell_d      = dwell_eff;
          tmr_load_val = dwell_eff;
          if (count == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StSelect;
            tmr_load = 1'b1;
          end
        end
      end
      StSelect: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_expire) begin
          remain_d = remain_q - 1'b1;
          state_d  = (remain_q == (ADDR_W + 1)'(1)) ? StDone : StGap;
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          addr_d   = addr_q + 1'b1;  // natural wrap modulo 2**ADDR_W
          state_d  = StSelect;
          tmr_load = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    sel_en_d   = (state_d == StSelect);
    sel_addr_d = (state_d == StSelect) ? addr_d : sel_addr_q;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  // State, scan registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      dwell_q    <= '0;
      sel_en_q   <= 1'b0;
      sel_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      dwell_q    <= dwell_d;
      sel_en_q   <= sel_en_d;
      sel_addr_q <= sel_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sel_en   = sel_en_q;
  assign sel_addr = sel_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench: directed scans plus randomized scans against a timeline model.
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] start_addr;
  logic [6:0] count;
  logic [3:0] dwell;
  logic       abort;
  logic       sel_en;
  logic [5:0] sel_addr;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  logic [5:0] last_addr;

  always #5 clk = ~clk;

  decoder_scan_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .dwell      (dwell),
    .abort      (abort),
    .sel_en     (sel_en),
    .sel_addr   (sel_addr),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".sel_en"}, 32'(sel_en), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".sel_addr"}, 32'(sel_addr), 32'(last_addr));
  endtask

  // Called just after a negedge with the DUT idle. The expected waveform is computed
  // per cycle offset k from the start edge: each select occupies a period of d+1 cycles
  // (d enabled, then one gap), and the final gap slot is the done cycle.
  task automatic do_scan(input logic [5:0] sa, input logic [6:0] cnt, input logic [3:0] dw,
                         input int abort_k, input int rst_k, input bit poke);
    int d, n, idx, pos;
    bit exp_en, exp_done;
    logic [5:0] exp_addr;
    d = (dw == 0) ? 1 : int'(dw);
    n = (cnt == 0) ? 1 : int'(cnt) * (d + 1);
    start = 1'b1; start_addr = sa; count = cnt; dwell = dw; abort = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      idx      = (k - 1) / (d + 1);
      pos      = (k - 1) % (d + 1);
      exp_en   = (cnt != 0) && (pos < d);
      exp_done = (k == n);
      exp_addr = 6'((int'(sa) + idx) % 64);
      check_eq("scan.sel_en", 32'(sel_en), 32'(exp_en));
      check_eq("scan.busy", 32'(busy), 32'd1);
      check_eq("scan.done", 32'(done), 32'(exp_done));
      if (exp_en) begin
        check_eq("scan.sel_addr", 32'(sel_addr), 32'(exp_addr));
        last_addr = exp_addr;
      end
      if (k == abort_k) begin
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort");
        return;
      end
      if (k == rst_k) begin
        start = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        last_addr = '0;
        check_idle("midreset");
        rst_n = 1'b1;
        return;
      end
      if (poke) begin
        start      = 1'($urandom_range(0, 1));
        start_addr = 6'($urandom);
        count      = 7'($urandom_range(0, 64));
        dwell      = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_idle("end");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ak, rk, ncyc;
    logic [6:0] rc;
    logic [3:0] rd;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    start_addr = 6'd9; count = 7'd5; dwell = 4'd3;
    last_addr = '0;

    // Reset held with start asserted.
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle("post_reset");
    end

    do_scan(6'd5, 7'd3, 4'd2, 0, 0, 1'b0);    // basic, done at T+9
    do_scan(6'd62, 7'd4, 4'd0, 0, 0, 1'b0);   // wrap, zero dwell
    do_scan(6'd0, 7'd64, 4'd1, 0, 0, 1'b0);   // full sweep, done at T+128
    do_scan(6'd33, 7'd0, 4'd7, 0, 0, 1'b0);   // empty scan
    do_scan(6'd5, 7'd3, 4'd2, 4, 0, 1'b0);    // abort in second select
    @(negedge clk);
    check_idle("after_abort");

    // Abort together with start in IDLE.
    start = 1'b1; abort = 1'b1; start_addr = 6'd17; count = 7'd3; dwell = 4'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle("abort_start");
    @(negedge clk);
    check_idle("abort_start2");

    do_scan(6'd10, 7'd5, 4'd3, 0, 0, 1'b1);   // starts while busy are ignored
    do_scan(6'd20, 7'd3, 4'd2, 0, 5, 1'b0);   // reset during second select
    @(negedge clk);
    check_idle("after_midreset");

    // Randomized scans with occasional abort or reset.
    for (int i = 0; i < 25; i++) begin
      rc   = 7'($urandom_range(0, 64));
      rd   = 4'($urandom);
      ncyc = (rc == 0) ? 1 : int'(rc) * (((rd == 0) ? 1 : int'(rd)) + 1);
      ak   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ncyc)) : 0;
      rk   = (ak == 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, ncyc)) : 0;
      do_scan(6'($urandom), rc, rd, ak, rk, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream sequencer for the 6-to-64 one-hot decoder stage.
- Drives the decoder's enable and 6-bit select, stepping through a programmable run of consecutive addresses that wraps modulo 64.
- Holds each select for a programmable dwell time, then inserts a one-cycle break-before-make gap with the enable low, so two decoder outputs are never high back-to-back.
- Reports busy and done to the controlling logic.

Parameters:
- ADDR_W, 6, width of the select address; decoder depth is 2**ADDR_W.
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request a scan; sampled only in IDLE.
- start_addr  input  ADDR_W  first address of the scan; captured on an accepted start.
- count  input  ADDR_W+1  number of selects, 0..64; captured on an accepted start.
- dwell  input  DWELL_W  cycles per select; 0 is treated as 1; captured on an accepted start.
- abort  input  1  terminate the scan immediately.
- sel_en  output  1  decoder enable.
- sel_addr  output  ADDR_W  decoder select.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (rst_n low at a clock edge): state goes to IDLE; sel_en=0, sel_addr=0, busy=0, done=0; internal counters cleared. Reset mid-scan abandons the scan with no done pulse.
- All outputs are registered.
- States:
  - IDLE -> SELECT on start when count!=0.
  - IDLE -> DONE on start when count==0.
  - SELECT -> GAP when the dwell expires and selects remain.
  - SELECT -> DONE after the last select.
  - GAP -> SELECT.
  - DONE -> IDLE.
- IDLE: sel_en=0, busy=0. sel_addr holds its last value.
- SELECT: sel_en=1 and sel_addr=current address for exactly max(dwell,1) cycles.
- GAP: sel_en=0 for exactly 1 cycle. The address advances to (addr+1) mod 64, so 63 wraps to 0.
- DONE: sel_en=0, done=1 for 1 cycle.
- Timing, with start accepted at edge T:
  - First SELECT cycle is T+1.
  - done is high in cycle T + count*(max(dwell,1)+1).
  - count=0 gives done in cycle T+1 and sel_en is never asserted.
- Start is ignored while busy. Inputs are captured only on an accepted start, so later changes have no effect on a scan in progress.
- Abort has priority over everything except reset:
  - From any non-IDLE state, go to IDLE at the next edge with sel_en=0 and no done pulse.
  - Abort together with start in IDLE: start is ignored.
- Start in the DONE cycle is ignored; a new start is accepted from IDLE only.
- Selects per scan: count=64 visits every address once, with wrap.
- Width rules: count is ADDR_W+1 bits so 64 is representable. The remaining-select counter decrements once per SELECT exit. The dwell counter is DWELL_W bits and is reloaded on entry to SELECT.

Decomposition:
- Shared package:
  - State enum: IDLE, SELECT, GAP, DONE.
  - ADDR_W and DWELL_W defaults.
  - DEPTH = 2**ADDR_W.
- One natural sub-module, dwell_timer:
  - Loadable down-counter with a load input and an expire output.
  - Instantiated once. The FSM and the address/count registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while start=1 -> sel_en=0, sel_addr=0, busy=0, done=0 throughout, and no scan starts after release.
- Basic scan: start_addr=5, count=3, dwell=2 -> sel_en high 2 cycles each on addresses 5, 6, 7, with a 1-cycle gap between; done at T+9; busy high T+1..T+9.
- Wrap and zero dwell: start_addr=62, count=4, dwell=0 -> addresses 62, 63, 0, 1, one cycle each with gaps; done at T+8.
- Full and zero counts: count=64, dwell=1, start_addr=0 -> 64 distinct addresses, done at T+128. count=0 -> done at T+1, sel_en never high.
- Abort: abort asserted during the second select of the basic scan -> sel_en=0 and busy=0 next cycle, no done. Abort+start in IDLE -> no scan.
- Start while busy: start with different inputs mid-scan -> ignored, original scan completes unchanged. Reset asserted mid-SELECT -> outputs cleared at the next edge.
